// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one 1-bit step per clock, iterated amt times.
// state   | meaning
// S_IDLE  | waiting for start; outputs hold last result
// S_SHIFT | one 1-bit step per edge, counting cnt down to 1
// S_DONE  | one-cycle done pulse, result/cout/zero valid
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   step_val;
    logic               step_c;

    always_comb begin
        step_val = sh_q;
        step_c   = 1'b0;
        case (op_q)
            OP_LSL: begin
                step_val = {sh_q[WIDTH-2:0], 1'b0};
                step_c   = sh_q[WIDTH-1];
            end
            OP_LSR: begin
                step_val = {1'b0, sh_q[WIDTH-1:1]};
                step_c   = sh_q[0];
            end
            OP_ASR: begin
                step_val = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                step_c   = sh_q[0];
            end
            OP_ROL: begin
                step_val = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
                step_c   = sh_q[WIDTH-1];
            end
            default: begin
                step_val = sh_q;
                step_c   = 1'b0;
            end
        endcase
    end

    // zero is captured on entry to S_DONE so it is valid alongside done.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d   = din;
                    cnt_d  = amt;
                    op_d   = op;
                    cout_d = 1'b0;
                    if (amt == '0) begin
                        state_d = S_DONE;
                        zero_d  = (din == '0);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sh_d   = step_val;
                cout_d = step_c;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                    zero_d  = (step_val == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            op_q    <= OP_LSL;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = sh_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: hand-computed results, latency and handshake checks.
module tb_seq_shift_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] din;
    logic [3:0] amt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .din    (din),
        .amt    (amt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op and follow it to completion. inj > 0 pulses a stray start
    // (din=0xFF) for one edge at that cycle count, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                          input logic [3:0] a, input logic [7:0] exp_res,
                          input logic exp_c, input logic exp_z, input int inj);
        int n;
        int lat;
        int extra;
        @(negedge clk);
        op    = o;
        din   = d;
        amt   = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        din = 8'h00;
        lat = -1;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (start) begin
                start = 1'b0;
                din   = 8'h00;
            end
            if (n == 1) check({tag, "_busy1"}, 32'(busy), 32'd1);
            if (done) begin
                lat = n;
                break;
            end
            if (n == inj) begin
                op    = 2'b00;
                din   = 8'hFF;
                amt   = 4'd1;
                start = 1'b1;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(int'(a) + 1));
        check({tag, "_res"}, 32'(result), 32'(exp_res));
        check({tag, "_cout"}, 32'(cout), 32'(exp_c));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            if (done) extra++;
            if (k < 2) @(negedge clk);
        end
        check({tag, "_onedone"}, 32'(extra), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int dcount;
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        din   = 8'hAA;
        amt   = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout",   32'(cout),   32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        start = 1'b0;
        rst   = 1'b0;

        run_op("lsl96",  2'b00, 8'h96, 4'd3,  8'hB0, 1'b0, 1'b0, 0);
        run_op("asr96",  2'b10, 8'h96, 4'd2,  8'hE5, 1'b1, 1'b0, 0);
        run_op("rol81",  2'b11, 8'h81, 4'd1,  8'h03, 1'b1, 1'b0, 0);
        run_op("amt0",   2'b01, 8'h5A, 4'd0,  8'h5A, 1'b0, 1'b0, 0);
        run_op("lsr9",   2'b01, 8'h01, 4'd9,  8'h00, 1'b0, 1'b1, 0);
        run_op("rol9",   2'b11, 8'h01, 4'd9,  8'h02, 1'b0, 1'b0, 0);
        run_op("ignore", 2'b00, 8'h0F, 4'd4,  8'hF0, 1'b0, 1'b0, 2);
        run_op("asr15",  2'b10, 8'h80, 4'd15, 8'hFF, 1'b1, 1'b0, 0);
        run_op("lsl8",   2'b00, 8'hFF, 4'd8,  8'h00, 1'b1, 1'b1, 0);

        // Abort an amt=5 op mid-shift.
        @(negedge clk);
        op    = 2'b00;
        din   = 8'hFF;
        amt   = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout",   32'(cout),   32'd0);
        check("abort_zero",   32'(zero),   32'd0);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_nodone", 32'(dcount), 32'd0);

        run_op("post_rst", 2'b01, 8'h80, 4'd7, 8'h01, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
